// File: rtl/alu_pkg.sv
// Shared opcode, FSM state encoding and default widths for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DEFAULT_WIDTH   = 20;
  localparam int DEFAULT_SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_NOT  = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_XOR  = 4'd3,
    OP_ADD  = 4'd4,
    OP_ADC  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SBB  = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_ROL  = 4'd12,
    OP_ROR  = 4'd13,
    OP_CMP  = 4'd14,
    OP_CLRF = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  // Shift/rotate ops run one bit per cycle in the SHIFT state.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_step.sv
// Single-step combinational ALU datapath: logic, arithmetic and one-bit shift/rotate.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module alu_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [3:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] flag_res,
  output logic             cout
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] mask, am, bm, op_b, rot_in;
  logic             op_c, a_msb;
  logic [WIDTH:0]   sum, diff;
  logic             sum_c, diff_b;

  // Operand masking to the active width and selection of the adder inputs.
  always_comb begin
    mask   = mode ? {WIDTH{1'b1}} : {{(WIDTH-HW){1'b0}}, {HW{1'b1}}};
    am     = a & mask;
    bm     = b & mask;
    a_msb  = mode ? a[WIDTH-1] : a[HW-1];
    rot_in = mode ? {am[0], {(WIDTH-1){1'b0}}} : (WIDTH'(am[0]) << (HW-1));
    op_b   = bm;
    op_c   = 1'b0;
    case (op)
      OP_ADC, OP_SBB: op_c = cin;
      OP_INC, OP_DEC: op_b = WIDTH'(1);
      default:        op_c = 1'b0;
    endcase
    // Carry/borrow is taken at bit AW, just above the active MSB.
    sum    = {1'b0, am} + {1'b0, op_b} + (WIDTH+1)'(op_c);
    diff   = {1'b0, am} - {1'b0, op_b} - (WIDTH+1)'(op_c);
    sum_c  = mode ? sum[WIDTH]  : sum[HW];
    diff_b = mode ? diff[WIDTH] : diff[HW];
  end

  // Result and carry selection per opcode; flag_res differs from res only for CMP.
  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op)
      OP_NOT:                 res = ~am & mask;
      OP_AND:                 res = am & bm;
      OP_OR:                  res = am | bm;
      OP_XOR:                 res = am ^ bm;
      OP_ADD, OP_ADC, OP_INC: begin res = sum[WIDTH-1:0] & mask;  cout = sum_c;  end
      OP_SUB, OP_SBB, OP_DEC: begin res = diff[WIDTH-1:0] & mask; cout = diff_b; end
      OP_SHL:                 begin res = (am << 1) & mask;                   cout = a_msb; end
      OP_SHR:                 begin res = am >> 1;                            cout = am[0]; end
      OP_ROL:                 begin res = ((am << 1) | WIDTH'(a_msb)) & mask; cout = a_msb; end
      OP_ROR:                 begin res = (am >> 1) | rot_in;                 cout = am[0]; end
      OP_CMP:                 begin res = am;                                 cout = diff_b; end
      default:                begin res = '0;                                 cout = 1'b0;  end
    endcase
    flag_res = (op == OP_CMP) ? (diff[WIDTH-1:0] & mask) : res;
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: one request at a time, shifts/rotates iterate one bit per cycle.
// Latency: 1 cycle for non-shift ops, k+1 cycles for a shift/rotate by k>0.
// Backpressure: in_ready only in IDLE; result and flags hold in DONE until out_ready.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_sign,
  output logic             flag_carry
);

  localparam int HW = WIDTH / 2;

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, sign_q, sign_d, carry_q, carry_d;
  logic [3:0]         op_q, op_d;
  logic               mode_q, mode_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, k;

  logic [3:0]         st_op;
  logic               st_mode, st_cin;
  logic [WIDTH-1:0]   st_a, st_b, st_res, st_fres;
  logic               st_cout;

  function automatic logic [WIDTH-1:0] mask_aw(input logic [WIDTH-1:0] v, input logic md);
    return md ? v : (v & {{(WIDTH-HW){1'b0}}, {HW{1'b1}}});
  endfunction

  function automatic logic msb_aw(input logic [WIDTH-1:0] v, input logic md);
    return md ? v[WIDTH-1] : v[HW-1];
  endfunction

  assign k = b[SHAMT_W-1:0];

  // Datapath operands: the live request in IDLE, the working value while shifting.
  always_comb begin
    if (state_q == SHIFT) begin
      st_op = op_q;  st_mode = mode_q; st_a = result_q; st_b = '0; st_cin = 1'b0;
    end else begin
      st_op = op;    st_mode = mode;   st_a = a;        st_b = b;  st_cin = carry_q;
    end
  end

  alu_step #(.WIDTH(WIDTH)) u_step (
    .op       (st_op),
    .mode     (st_mode),
    .a        (st_a),
    .b        (st_b),
    .cin      (st_cin),
    .res      (st_res),
    .flag_res (st_fres),
    .cout     (st_cout)
  );

  // Next-state, working value and flag update logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    carry_d  = carry_q;
    op_d     = op_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = op;
          mode_d = mode;
          if (is_shift(op) && (k != '0)) begin
            state_d  = SHIFT;
            result_d = mask_aw(a, mode);
            cnt_d    = k;
          end else begin
            state_d = DONE;
            if (is_shift(op)) begin
              // Zero-count shift: nothing moves, so no bit is shifted out.
              result_d = mask_aw(a, mode);
              zero_d   = (mask_aw(a, mode) == '0);
              sign_d   = msb_aw(a, mode);
              carry_d  = 1'b0;
            end else if (op == OP_CLRF) begin
              result_d = '0;
              zero_d   = 1'b0;
              sign_d   = 1'b0;
              carry_d  = 1'b0;
            end else begin
              result_d = st_res;
              zero_d   = (st_fres == '0);
              sign_d   = msb_aw(st_fres, mode);
              carry_d  = st_cout;
            end
          end
        end
      end
      SHIFT: begin
        result_d = st_res;
        cnt_d    = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
          zero_d  = (st_res == '0);
          sign_d  = msb_aw(st_res, mode_q);
          carry_d = st_cout;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      op_q     <= 4'd0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_sign  = sign_q;
  assign flag_carry = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu with a queue scoreboard and an independent reference model.
// Latency: checks 1 cycle for non-shift ops and k+1 for shifts by k.
// Backpressure: exercises held out_ready and ignored requests while busy.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W  = 20;
  localparam int SW = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_zero, flag_sign, flag_carry;

  seq_alu #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_sign  (flag_sign),
    .flag_carry (flag_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z, s, c;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_carry  = 1'b0;

  // Reference model written from the opcode definitions, using 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic md,
                                 input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    exp_t e;
    int aw, k, r;
    longint unsigned mask, am, bm, t, res, fr;
    logic c;
    aw   = md ? W : W / 2;
    mask = (64'd1 << aw) - 64'd1;
    am   = 64'(av) & mask;
    bm   = 64'(bv) & mask;
    k    = int'(bv[SW-1:0]);
    r    = k % aw;
    c    = 1'b0;
    res  = 0;
    case (o)
      OP_NOT: res = ~am & mask;
      OP_AND: res = am & bm;
      OP_OR:  res = am | bm;
      OP_XOR: res = am ^ bm;
      OP_ADD: begin t = am + bm;               res = t & mask; c = ((t >> aw) & 1) != 0; end
      OP_ADC: begin t = am + bm + 64'(ci);     res = t & mask; c = ((t >> aw) & 1) != 0; end
      OP_INC: begin t = am + 1;                res = t & mask; c = ((t >> aw) & 1) != 0; end
      OP_SUB, OP_CMP: begin t = am - bm;       res = t & mask; c = (am < bm); end
      OP_SBB: begin t = am - bm - 64'(ci);     res = t & mask; c = (am < bm + 64'(ci)); end
      OP_DEC: begin t = am - 1;                res = t & mask; c = (am == 0); end
      OP_SHL: begin
        res = (k >= aw) ? 0 : ((am << k) & mask);
        c   = (k >= 1 && k <= aw) ? (((am >> (aw - k)) & 1) != 0) : 1'b0;
      end
      OP_SHR: begin
        res = (k >= aw) ? 0 : (am >> k);
        c   = (k >= 1 && k <= aw) ? (((am >> (k - 1)) & 1) != 0) : 1'b0;
      end
      OP_ROL: begin
        res = ((am << r) | (am >> (aw - r))) & mask;
        c   = (k != 0) ? ((res & 1) != 0) : 1'b0;
      end
      OP_ROR: begin
        res = ((am >> r) | (am << (aw - r))) & mask;
        c   = (k != 0) ? (((res >> (aw - 1)) & 1) != 0) : 1'b0;
      end
      default: res = 0;
    endcase
    fr = res;
    if (o == OP_CMP) res = am;
    e.res = W'(res);
    e.z   = (fr == 0);
    e.s   = ((fr >> (aw - 1)) & 1) != 0;
    e.c   = c;
    if (o == OP_CLRF) begin e.z = 1'b0; e.s = 1'b0; e.c = 1'b0; end
    e.lat = (is_shift(o) && k != 0) ? k + 1 : 1;
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic md, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    op = o; mode = md; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = model(o, md, av, bv, m_carry);
    m_carry = e.c;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic check_pop(input string nm, input int lat);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expectation queued", nm);
      return;
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1 || lat != e.lat) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid=%b latency=%0d required 1/%0d", nm, out_valid, lat, e.lat);
    end
    n_checks++;
    if ({result, flag_zero, flag_sign, flag_carry} !== {e.res, e.z, e.s, e.c}) begin
      n_fail++;
      $display("FAIL %s_result: got res=%h z=%b s=%b c=%b required res=%h z=%b s=%b c=%b",
               nm, result, flag_zero, flag_sign, flag_carry, e.res, e.z, e.s, e.c);
    end
  endtask

  task automatic consume(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_handshake: out_valid=%b in_ready=%b required 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] o, input logic md,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat;
    issue(o, md, av, bv);
    wait_valid(lat);
    check_pop(nm, lat);
    consume(nm);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    n_checks++;
    if ({in_ready, out_valid, result, flag_zero, flag_sign, flag_carry} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h flags=%b%b%b required 1 0 0 000",
               in_ready, out_valid, result, flag_zero, flag_sign, flag_carry);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    m_carry = 1'b0;
  endtask

  task automatic test_add();
    run_op("add_wrap", OP_ADD, 1'b1, 20'hFFFFF, 20'h00001);
  endtask

  task automatic test_adc();
    run_op("adc_half_carry", OP_ADC, 1'b0, 20'h003FF, 20'h00000);
    run_op("adc_half_mask", OP_ADC, 1'b0, 20'hFFC00, 20'h00000);
  endtask

  task automatic test_sub_cmp();
    run_op("sub_neg", OP_SUB, 1'b1, 20'd5, 20'd7);
    run_op("cmp_neg", OP_CMP, 1'b1, 20'd5, 20'd7);
    run_op("cmp_eq_half", OP_CMP, 1'b0, 20'h12345, 20'hAB345);
  endtask

  task automatic test_logic_arith();
    logic [3:0]   ops [10] = '{OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC, OP_SBB, OP_ADC, OP_CLRF, OP_DEC};
    logic         mds [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] as  [10] = '{20'h0F0F0, 20'hF0F0F, 20'h12300, 20'hAAAAA, 20'hFFFFF, 20'h00000, 20'h00003, 20'h00010, 20'h55555, 20'h00000};
    logic [W-1:0] bs  [10] = '{20'h00000, 20'h0FF00, 20'h000C5, 20'hAAAAA, 20'h00000, 20'h00000, 20'h00003, 20'h00020, 20'h12345, 20'h00000};
    for (int i = 0; i < 10; i++) run_op($sformatf("logic_arith_%0d", i), ops[i], mds[i], as[i], bs[i]);
  endtask

  task automatic test_shift();
    int lat;
    issue(OP_SHL, 1'b1, 20'h00001, 20'd3);
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== (i == 4)) begin
        n_fail++;
        $display("FAIL shl_busy_c%0d: in_ready=%b out_valid=%b required 0/%b", i, in_ready, out_valid, (i == 4));
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    lat = 4;
    check_pop("shl3", lat);
    consume("shl3");
    run_op("ror_half", OP_ROR, 1'b0, 20'h00001, 20'd1);
    run_op("shr_full", OP_SHR, 1'b1, 20'h80003, 20'd2);
    run_op("shl_ge_aw", OP_SHL, 1'b0, 20'h003FF, 20'd25);
    run_op("shl_eq_aw", OP_SHL, 1'b0, 20'h00201, 20'd10);
    run_op("rol_wrap", OP_ROL, 1'b0, 20'h00301, 20'd13);
    run_op("shl_zero", OP_SHL, 1'b1, 20'h80000, 20'd0);
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    issue(OP_XOR, 1'b1, 20'h0F00F, 20'hFF0F0);
    e = sb[0];
    wait_valid(lat);
    check_pop("bp_xor", lat);
    for (int i = 0; i < 5; i++) begin
      op = OP_ADD; mode = 1'b1; a = 20'd1; b = 20'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, result, flag_zero, flag_sign, flag_carry} !== {1'b1, 1'b0, e.res, e.z, e.s, e.c}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: v=%b rdy=%b res=%h flags=%b%b%b required 1 0 %h %b%b%b",
                 i, out_valid, in_ready, result, flag_zero, flag_sign, flag_carry, e.res, e.z, e.s, e.c);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_ignored_%0d: out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op($sformatf("rand_%0d", i), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             W'($urandom), W'($urandom));
  endtask

  task automatic test_reset_midshift();
    issue(OP_SHL, 1'b1, 20'h00003, 20'd10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, flag_zero, flag_sign, flag_carry} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_midshift: in_ready=%b out_valid=%b res=%h flags=%b%b%b required 1 0 0 000",
               in_ready, out_valid, result, flag_zero, flag_sign, flag_carry);
    end
    sb.delete();
    m_carry = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    run_op("post_reset_add", OP_ADD, 1'b1, 20'h12345, 20'h11111);
    run_op("post_reset_adc", OP_ADC, 1'b1, 20'h00001, 20'h00001);
  endtask

  initial begin
    test_reset();
    test_add();
    test_adc();
    test_sub_cmp();
    test_logic_arith();
    test_shift();
    test_backpressure();
    test_random();
    test_reset_midshift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 20, full-word datapath width (even, >=4).
REQ-002 SHALL have parameter SHAMT_W, default 5, width of shift/rotate count field.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  4  opcode from alu_pkg.
REQ-008 SHALL have port mode  input  1  1 = full word (WIDTH), 0 = half word (WIDTH/2 LSBs).
REQ-009 SHALL have ports a, b  input  WIDTH  operands; b[SHAMT_W-1:0] is the count for shifts/rotates.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have ports flag_zero, flag_sign, flag_carry  output  1 each  registered status flags.

Function
REQ-014 Request SHALL be accepted only on an edge where in_valid && in_ready; in_ready = (state == IDLE).
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE: IDLE->DONE on accept of a non-shift op or a shift with count 0; IDLE->SHIFT on accept of a shift/rotate with count k>0; SHIFT->DONE after k one-bit steps; DONE->IDLE on out_valid && out_ready.
REQ-016 out_valid SHALL equal (state == DONE); result and flags SHALL be held stable while out_valid && !out_ready.
REQ-017 Latency SHALL be 1 cycle (accept edge to out_valid) for non-shift ops and k+1 cycles for shift/rotate with count k.
REQ-018 Opcodes SHALL be 0 NOT, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 ADC, 6 SUB, 7 SBB, 8 INC, 9 DEC, 10 SHL, 11 SHR, 12 ROL, 13 ROR, 14 CMP, 15 CLRF.
REQ-019 Active width AW SHALL be WIDTH (mode 1) or WIDTH/2 (mode 0); result bits at and above AW SHALL be 0; mode is sampled at accept.
REQ-020 ADD/ADC/INC SHALL set carry = carry-out of bit AW-1; ADC adds the stored flag_carry.
REQ-021 SUB/SBB/DEC SHALL compute a - b (- flag_carry for SBB) modulo 2^AW with carry = borrow out.
REQ-022 SHL SHALL move bits toward the MSB, SHR toward the LSB, filling 0; carry = last bit shifted out; k >= AW SHALL yield result 0.
REQ-023 ROL/ROR SHALL rotate within AW bits k times; carry = last bit moved across the end.
REQ-024 NOT/AND/OR/XOR SHALL clear carry.
REQ-025 CMP SHALL set flags as for SUB and return result = a (AW-masked).
REQ-026 CLRF SHALL clear all three flags and return result 0.
REQ-027 flag_zero SHALL equal (result[AW-1:0] == 0), flag_sign SHALL equal result[AW-1]; all flags SHALL update on the edge entering DONE, except CLRF, which clears them.
REQ-028 Requests presented while in_ready = 0 SHALL be ignored, not queued.

Reset
REQ-029 rst SHALL force state IDLE, result 0, all flags 0, out_valid 0, in_ready 1 immediately, including during SHIFT or DONE; an in-flight operation SHALL be discarded.

Structure
REQ-030 Opcode constants, state encoding and default WIDTH SHALL reside in shared package alu_pkg.
REQ-031 Single-step combinational datapath (logic, arithmetic, one-bit shift/rotate) SHALL be sub-module alu_step; seq_alu holds FSM, count register and flags.

Verification (WIDTH = 20)
REQ-032 ADD, mode 1, a=0xFFFFF, b=0x00001 -> result 0x00000, zero=1, carry=1, out_valid 1 cycle after accept.
REQ-033 With carry=1, then ADC mode 0, a=0x003FF, b=0 -> result 0x00000, zero=1, carry=1; a=0xFFC00, b=0 -> result 0x00001.
REQ-034 SUB mode 1, a=5, b=7 -> result 0xFFFFE, sign=1, carry=1, zero=0; CMP same operands -> result 0x00005, same flags.
REQ-035 SHL mode 1, a=0x00001, b=3 -> in_ready low for 4 cycles, result 0x00008 at cycle 4; ROR mode 0, a=0x001, b=1 -> result 0x200, carry=1.
REQ-036 out_ready held 0 for 5 cycles after out_valid -> result/flags constant, in_ready 0, new in_valid ignored; accepted on first out_ready=1.
REQ-037 rst asserted at step 2 of SHL with b=10 -> outputs reset asynchronously; after release, the next ADD completes normally with no residue.
